// File: rtl/pulse_burst_gen.sv
// Burst generator for 3-bit negative-edge pulse counters: clears the counter,
// then issues a programmed number of single-cycle pulses separated by low gaps.
module pulse_burst_gen #(
  parameter int CNT_W = 3,
  parameter int GAP_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             pulse_o,
  output logic             count_nreset_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W:0]   remaining_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W:0]   REM_ONE = (CNT_W+1)'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           state_reg;
  logic [GAP_W-1:0] gap_len_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [CNT_W:0]   remaining_reg;
  logic             pulse_reg;
  logic             nreset_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CNT_W:0]   load_val;

  // A zero length request means a full wrap of the downstream counter.
  assign load_val = (count_i == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, count_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= S_IDLE;
      gap_len_reg   <= '0;
      gap_cnt_reg   <= '0;
      remaining_reg <= '0;
      pulse_reg     <= 1'b0;
      nreset_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          pulse_reg  <= 1'b0;
          nreset_reg <= 1'b1;
          busy_reg   <= 1'b0;
          if (start_i && !abort_i) begin
            gap_len_reg   <= gap_i;
            remaining_reg <= load_val;
            nreset_reg    <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          nreset_reg <= 1'b1;
          if (abort_i) begin
            busy_reg      <= 1'b0;
            remaining_reg <= '0;
            state_reg     <= S_IDLE;
          end else begin
            pulse_reg <= 1'b1;
            state_reg <= S_PULSE;
          end
        end
        S_PULSE: begin
          // The pulse already in flight is never truncated; it ends here.
          pulse_reg     <= 1'b0;
          remaining_reg <= remaining_reg - REM_ONE;
          if (abort_i) begin
            busy_reg      <= 1'b0;
            remaining_reg <= '0;
            state_reg     <= S_IDLE;
          end else if (remaining_reg == REM_ONE) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            gap_cnt_reg <= gap_len_reg;
            state_reg   <= S_GAP;
          end
        end
        S_GAP: begin
          if (abort_i) begin
            busy_reg      <= 1'b0;
            remaining_reg <= '0;
            state_reg     <= S_IDLE;
          end else if (gap_cnt_reg == '0) begin
            pulse_reg <= 1'b1;
            state_reg <= S_PULSE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
          end
        end
        S_DONE: begin
          remaining_reg <= '0;
          state_reg     <= S_IDLE;
        end
        default: begin
          pulse_reg     <= 1'b0;
          nreset_reg    <= 1'b1;
          busy_reg      <= 1'b0;
          remaining_reg <= '0;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

  // Every output is a bare flop so async/edge-sensitive consumers see no glitches.
  assign pulse_o        = pulse_reg;
  assign count_nreset_o = nreset_reg;
  assign busy_o         = busy_reg;
  assign done_o         = done_reg;
  assign remaining_o    = remaining_reg;

endmodule

// File: doc/pulse_burst_gen.md
Name: pulse_burst_gen

Overview:
Produces a programmed burst of clean single-cycle pulses, plus a counter clear, for the 3-bit negative-edge pulse counters in the MAC datapath. It is the transmitting side of the pulse/nreset interface those counters consume. Each pulse is followed by at least one low cycle, so every pulse has a falling edge the counter can see. A one-cycle completion flag tells the MAC sequencer when the downstream count is final.

Parameters:
CNT_W, 3, width of the burst-length input; must match the downstream counter width.
GAP_W, 2, width of the inter-pulse gap input.

Ports:
clk_i  input  1  system clock; all state updates on the rising edge.
reset_i  input  1  asynchronous, active-high reset.
start_i  input  1  request a burst; sampled only in IDLE.
abort_i  input  1  cancel the burst in progress.
count_i  input  CNT_W  burst length; value 0 means 2^CNT_W pulses.
gap_i  input  GAP_W  low cycles between pulses, minus 1.
pulse_o  output  1  pulse to the counter's pulse_i input.
count_nreset_o  output  1  active-low clear to the counter's count_nreset_i input.
busy_o  output  1  burst in progress.
done_o  output  1  one-cycle completion strobe.
remaining_o  output  CNT_W+1  pulses not yet issued.

Behaviour:
- Clock and reset: single clock clk_i; reset_i is asynchronous, active-high.
- Reset values:
  - state=IDLE, pulse_o=0, busy_o=0, done_o=0, remaining_o=0.
  - count_nreset_o=0, so the downstream counter is held cleared during reset.
  - count_nreset_o rises to 1 on the first clk_i edge after reset_i deasserts.
- Glitch-free outputs: pulse_o and count_nreset_o each come directly from a dedicated flop, with no combinational decode. Both drive async or edge-sensitive logic downstream.
- States: IDLE, CLEAR, PULSE, GAP, DONE.
- IDLE:
  - If start_i=1 and abort_i=0, accept the request.
  - On accept: latch count_i and gap_i; load remaining_o with count_i, or 2^CNT_W when count_i=0; go to CLEAR.
  - count_i and gap_i are ignored after acceptance.
- CLEAR: one cycle; count_nreset_o=0, pulse_o=0, busy_o=1; go to PULSE.
- PULSE:
  - One cycle; pulse_o=1, busy_o=1; remaining_o decrements (new value visible next cycle).
  - If remaining_o was 1, go to DONE; otherwise go to GAP.
- GAP: pulse_o=0 for gap_q+1 cycles (1 to 2^GAP_W), using an internal gap counter; then go to PULSE.
- DONE: one cycle; done_o=1, busy_o=0, remaining_o=0; go to IDLE.
- Latency: accept edge at cycle 0 gives CLEAR in cycle 1 and the first pulse in cycle 2.
- Pulse cadence: period is gap_q+2 cycles; done_o asserts the cycle after the last pulse.
- Busy window: busy_o=1 exactly in CLEAR, PULSE and GAP.
- start_i while busy or in DONE: ignored; no queuing.
- abort_i in CLEAR, PULSE or GAP: next state is IDLE, remaining_o=0, pulse_o=0, done_o stays 0. An abort sampled in a PULSE cycle does not truncate that pulse.
- abort_i with start_i in IDLE: abort wins; nothing is accepted.
- abort_i in IDLE or DONE: no effect.
- Pulse count: the number of pulse_o high cycles in a completed burst equals the programmed length exactly. The downstream counter therefore reads count_i mod 2^CNT_W when done_o is high.
- reset_i mid-burst: all state returns to reset values immediately, asynchronously; pulse_o drops at once and no done_o is issued.

Test Plan:
- count_i=3, gap_i=0, start at cycle 0 -> count_nreset_o low in cycle 1; pulse_o high in cycles 2, 4, 6; done_o in cycle 7; busy_o high in cycles 1-6; attached Counter3Bit reads 3.
- count_i=0, gap_i=0 -> 8 pulses in cycles 2, 4, ..., 16; done_o in cycle 17; remaining_o walks 8 down to 0; counter wraps to 0.
- count_i=2, gap_i=3 -> pulses in cycles 2 and 7 (4 low cycles between them); done_o in cycle 8.
- count_i=5, abort_i pulsed in the cycle after the 2nd pulse -> exactly 2 pulses; no done_o; busy_o=0 and remaining_o=0 the next cycle; a new start is accepted immediately.
- start_i held high throughout a count_i=1 burst -> the second burst begins only from IDLE, i.e. its CLEAR is 2 cycles after done_o; start_i with abort_i in IDLE -> no burst.
- reset_i asserted asynchronously during a PULSE cycle -> pulse_o, busy_o and count_nreset_o go to 0 before the next edge; after release count_nreset_o=1 on the first clk_i edge, with no spurious done_o.
